alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one combinational 4-bit ALU (3-bit L,M,N opcode) between two requesters. Each requester issues op/A/B over a valid/ready channel and receives the 4-bit result over a valid/ready response channel. The block holds ALU operands stable for a configurable settle time, registers the ALU output, and returns it to the granted requester. It sits between the two client blocks and the ALU instance.

Parameters:
WIDTH, 4, operand/result width; must match the ALU.
OP_W, 3, opcode width (bit2=L, bit1=M, bit0=N).
EXEC_CYCLES, 1, cycles operands are held before the ALU result is sampled (1..15); covers ripple-adder and multiplier settle.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  2  per-requester request valid; bit i = requester i.
req_ready  output  2  per-requester request accept; at most one bit high.
req_op  input  2*OP_W  packed opcodes; [OP_W*i +: OP_W] = requester i.
req_a  input  2*WIDTH  packed operand A per requester.
req_b  input  2*WIDTH  packed operand B per requester.
rsp_valid  output  2  per-requester response valid; at most one bit high.
rsp_ready  input  2  per-requester response accept.
rsp_result  output  WIDTH  result, shared by both response channels; qualified by rsp_valid.
alu_op  output  OP_W  to ALU {L,M,N}.
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_s  input  WIDTH  from ALU S.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, rr_last=1 (requester 0 has priority first), req_ready=0, rsp_valid=0, rsp_result=0, alu_op/alu_a/alu_b=0, busy=0, settle counter=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant g = round-robin choice among req_valid bits; the bit other than rr_last wins a tie.
  - req_ready[g] is combinational and is high in the same cycle only.
  - On a handshake: capture op/a/b into registers, rr_last<=g, counter<=EXEC_CYCLES-1, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - alu_op/alu_a/alu_b are driven from the capture registers and are stable for the whole state.
  - If counter==0: rsp_result<=alu_s, go to RESP. Otherwise decrement the counter.
- RESP:
  - rsp_valid[g]=1 and rsp_result stays stable until rsp_ready[g]=1.
  - On that handshake, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Latency: request handshake at cycle T gives rsp_valid at T+1+EXEC_CYCLES. Minimum issue interval is 2+EXEC_CYCLES cycles.
- Outside EXEC, alu_* outputs hold their last value and do not toggle.
- One operation is in flight globally. req_ready=0 in EXEC and RESP regardless of req_valid.
- A requester may drop req_valid before being granted; no state is kept for it.
- A requester may assert req_valid while its own response is pending. It is only considered once the block returns to IDLE.
- Arithmetic is done entirely by the ALU; the result is the 4-bit ALU output (mod 16). Carry and overflow are not returned.
- All 8 opcodes are legal:
  - 000 B-A; 001 -B; 010 A+B; 011 A-B
  - 100 A&B; 101 A|B; 110 A*B (low nibble); 111 A^B
- Reset in any state, including mid-EXEC or mid-RESP: the next cycle returns to IDLE with reset values, the pending operation is dropped, and no response is produced.

Decomposition:
- Package alu_share_pkg:
  - state enum (IDLE, EXEC, RESP)
  - opcode constants OP_BSUBA=000, OP_NEGB=001, OP_ADD=010, OP_SUB=011, OP_AND=100, OP_OR=101, OP_MUL=110, OP_XOR=111
  - WIDTH and OP_W defaults
- Sub-module rr_arb2:
  - combinational 2-way round-robin grant from req_valid and rr_last
  - outputs a one-hot grant plus a grant index

Test Plan:
1. After reset: req0 op=010 a=3 b=4, rsp_ready=11, accepted at T -> alu_op=010, alu_a=3, alu_b=4 at T+1; rsp_valid=01, rsp_result=7 at T+2; busy low at T+3.
2. Both requesters valid every cycle: req0 op=100 a=C b=A, req1 op=110 a=3 b=5 -> grant order 0,1,0,1; results 8 and F alternate; req_ready never 11.
3. Wrap-around: op=010 a=F b=2 -> 1; op=011 a=2 b=5 -> D; op=001 b=1 -> F; op=000 a=1 b=4 -> 3.
4. Backpressure: rsp_ready[0]=0 for 5 cycles with req1 valid -> rsp_valid[0] held, rsp_result constant, req_ready=00 throughout; req1 granted the cycle after the rsp0 handshake.
5. EXEC_CYCLES=3, ALU output model delayed 2 cycles -> correct result at T+4; alu_* stable T+1..T+3.
6. Reset asserted in second EXEC cycle -> next cycle all outputs 0 and busy=0; no rsp_valid for the dropped op; simultaneous requests afterwards grant requester 0 first.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_share_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_OP_W  = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  // Opcode bits are {L,M,N} on the ALU
  localparam logic [DEF_OP_W-1:0] OP_BSUBA = 3'b000;
  localparam logic [DEF_OP_W-1:0] OP_NEGB  = 3'b001;
  localparam logic [DEF_OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [DEF_OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [DEF_OP_W-1:0] OP_AND   = 3'b100;
  localparam logic [DEF_OP_W-1:0] OP_OR    = 3'b101;
  localparam logic [DEF_OP_W-1:0] OP_MUL   = 3'b110;
  localparam logic [DEF_OP_W-1:0] OP_XOR   = 3'b111;

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin grant: on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] reqValid,
  input  logic       rrLast,
  output logic [1:0] grant,
  output logic       grantIdx
);

  always_comb begin
    grantIdx = 1'b0;
    unique case (reqValid)
      2'b10:   grantIdx = 1'b1;
      2'b11:   grantIdx = ~rrLast;
      default: grantIdx = 1'b0;
    endcase
    grant[0] = reqValid[0] & ~grantIdx;
    grant[1] = reqValid[1] &  grantIdx;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two valid/ready requesters, one operation in flight.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int OP_W        = DEF_OP_W,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OP_W-1:0]  req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [OP_W-1:0]    alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_s,
  output logic               busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  stateT            state, stateNxt;
  logic             rrLast, gIdx;
  logic [1:0]       arbGrant;
  logic             arbIdx, accept;
  logic [OP_W-1:0]  opReg;
  logic [WIDTH-1:0] aReg, bReg, resReg;
  logic [3:0]       cnt;

  rr_arb2 uArb (
    .reqValid (req_valid),
    .rrLast   (rrLast),
    .grant    (arbGrant),
    .grantIdx (arbIdx)
  );

  always_comb begin
    stateNxt  = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = arbGrant;
        if (|req_valid) begin
          accept   = 1'b1;
          stateNxt = EXEC;
        end
      end
      EXEC: if (cnt == 4'd0) stateNxt = RESP;
      RESP: begin
        rsp_valid[gIdx] = 1'b1;
        // only the granted requester's ready completes the response
        if (rsp_ready[gIdx]) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rrLast <= 1'b1;
      gIdx   <= 1'b0;
      opReg  <= '0;
      aReg   <= '0;
      bReg   <= '0;
      resReg <= '0;
      cnt    <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        opReg  <= arbIdx ? req_op[2*OP_W-1:OP_W]  : req_op[OP_W-1:0];
        aReg   <= arbIdx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        bReg   <= arbIdx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        rrLast <= arbIdx;
        gIdx   <= arbIdx;
        cnt    <= CNT_INIT;
      end else if (state == EXEC) begin
        if (cnt == 4'd0) resReg <= alu_s;
        else             cnt    <= cnt - 4'd1;
      end
    end
  end

  // Operand registers only change on accept, so the ALU inputs are quiet outside EXEC
  assign alu_op     = opReg;
  assign alu_a      = aReg;
  assign alu_b      = bReg;
  assign rsp_result = resReg;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: scoreboard on the EXEC_CYCLES=1 instance, direct checks on a slow-ALU instance.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] reqValid, reqReady, rspValid, rspReady;
  logic [5:0] reqOp;
  logic [7:0] reqA, reqB;
  logic [3:0] rspResult, aluA, aluB, aluS;
  logic [2:0] aluOp;
  logic       busy;

  logic [1:0] reqValid2, reqReady2, rspValid2, rspReady2;
  logic [5:0] reqOp2;
  logic [7:0] reqA2, reqB2;
  logic [3:0] rspResult2, aluA2, aluB2, aluS2;
  logic [2:0] aluOp2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  typedef struct {int idx; logic [3:0] res;} expT;
  expT  sb[$];
  int   grants[$];
  logic [3:0] lastRsp;

  function automatic logic [3:0] aluRef(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'b000:  r = b - a;
      3'b001:  r = 4'd0 - b;
      3'b010:  r = a + b;
      3'b011:  r = a - b;
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a * b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  assign aluS = aluRef(aluOp, aluA, aluB);

  // Slow ALU: output lags its inputs by two cycles
  logic [3:0] d1, d2;
  always @(posedge clk) begin
    d1 <= aluRef(aluOp2, aluA2, aluB2);
    d2 <= d1;
  end
  assign aluS2 = d2;

  alu_share_ctrl #(.EXEC_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady),
    .req_op(reqOp), .req_a(reqA), .req_b(reqB), .rsp_valid(rspValid),
    .rsp_ready(rspReady), .rsp_result(rspResult), .alu_op(aluOp),
    .alu_a(aluA), .alu_b(aluB), .alu_s(aluS), .busy(busy)
  );

  alu_share_ctrl #(.EXEC_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .req_valid(reqValid2), .req_ready(reqReady2),
    .req_op(reqOp2), .req_a(reqA2), .req_b(reqB2), .rsp_valid(rspValid2),
    .rsp_ready(rspReady2), .rsp_result(rspResult2), .alu_op(aluOp2),
    .alu_a(aluA2), .alu_b(aluB2), .alu_s(aluS2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge and run the scoreboard for the first instance
  task automatic toNeg();
    expT e;
    @(negedge clk);
    chk("onehot", 32'((reqReady == 2'b11) || (rspValid == 2'b11)), 0);
    for (int i = 0; i < 2; i++)
      if (reqValid[i] && reqReady[i]) begin
        e.idx = i;
        e.res = aluRef(reqOp[3*i +: 3], reqA[4*i +: 4], reqB[4*i +: 4]);
        sb.push_back(e);
        grants.push_back(i);
      end
    for (int i = 0; i < 2; i++)
      if (rspValid[i] && rspReady[i]) begin
        chk("rsp expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp idx", i, e.idx);
          chk("rsp data", rspResult, e.res);
          lastRsp = rspResult;
        end
      end
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    toNeg();
    toPos();
  endtask

  task automatic setReq(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    reqOp[3*i +: 3] = op;
    reqA[4*i +: 4]  = a;
    reqB[4*i +: 4]  = b;
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound && sb.size() > 0; k++) step();
    chk("drain", sb.size(), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    reqValid = '0;
    reqValid2 = '0;
    toPos();
    toPos();
    reset = 1'b0;
  endtask

  task automatic doOp(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = grants.size();
    setReq(i, op, a, b);
    reqValid[i] = 1'b1;
    for (int k = 0; k < 10 && grants.size() == n; k++) step();
    reqValid = '0;
    chk("accept", grants.size(), n + 1);
    drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reqValid = '0; rspReady = '0; reqOp = '0; reqA = '0; reqB = '0;
    reqValid2 = '0; rspReady2 = 2'b11; reqOp2 = '0; reqA2 = '0; reqB2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", rspValid, 0);
    chk("rst rsp_result", rspResult, 0);
    chk("rst alu", {aluOp, aluA, aluB}, 0);
    chk("rst req_ready", reqReady, 0);

    // 1: single add, latency and busy
    rspReady = 2'b11;
    setReq(0, 3'b010, 4'h3, 4'h4);
    reqValid = 2'b01;
    toNeg(); chk("t1 req_ready", reqReady, 2'b01); chk("t1 busy T", busy, 0); toPos();
    reqValid = '0;
    toNeg(); chk("t1 alu", {aluOp, aluA, aluB}, {3'b010, 4'h3, 4'h4});
    chk("t1 rsp_valid T+1", rspValid, 0); chk("t1 busy T+1", busy, 1); toPos();
    toNeg(); chk("t1 rsp_valid", rspValid, 2'b01); chk("t1 result", rspResult, 4'h7); toPos();
    toNeg(); chk("t1 busy T+3", busy, 0); toPos();

    // 2: contention alternates grants
    doReset();
    grants.delete();
    setReq(0, 3'b100, 4'hC, 4'hA);
    setReq(1, 3'b110, 4'h3, 4'h5);
    reqValid = 2'b11;
    repeat (12) step();
    reqValid = '0;
    drain(20);
    chk("t2 grants", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("t2 order", grants[k], k % 2);

    // 3: wrap-around arithmetic
    doOp(0, 3'b010, 4'hF, 4'h2); chk("t3 add wrap", lastRsp, 4'h1);
    doOp(0, 3'b011, 4'h2, 4'h5); chk("t3 sub wrap", lastRsp, 4'hD);
    doOp(0, 3'b001, 4'h0, 4'h1); chk("t3 negb", lastRsp, 4'hF);
    doOp(0, 3'b000, 4'h1, 4'h4); chk("t3 bsuba", lastRsp, 4'h3);

    // 4: response backpressure; requester 1's ready must not complete requester 0's response
    rspReady = 2'b10;
    setReq(0, 3'b010, 4'h1, 4'h1);
    setReq(1, 3'b011, 4'h9, 4'h3);
    reqValid = 2'b01;
    step();
    reqValid = 2'b10;
    toNeg(); chk("t4 exec ready", reqReady, 0); toPos();
    repeat (5) begin
      toNeg();
      chk("t4 hold valid", rspValid, 2'b01);
      chk("t4 hold result", rspResult, 4'h2);
      chk("t4 hold ready", reqReady, 0);
      toPos();
    end
    rspReady = 2'b11;
    toNeg(); chk("t4 rsp0", rspValid, 2'b01); toPos();
    toNeg(); chk("t4 req1 grant", reqReady, 2'b10); toPos();
    reqValid = '0;
    drain(20);
    chk("t4 last", lastRsp, 4'h6);

    // 5: slow ALU with EXEC_CYCLES=3
    setReq(0, 3'b000, 4'h0, 4'h0);
    reqOp2 = 6'b000_110; reqA2 = 8'h03; reqB2 = 8'h05;
    reqValid2 = 2'b01;
    toNeg(); chk("t5 req_ready", reqReady2, 2'b01); toPos();
    reqValid2 = '0;
    repeat (3) begin
      toNeg();
      chk("t5 alu stable", {aluOp2, aluA2, aluB2}, {3'b110, 4'h3, 4'h5});
      chk("t5 no rsp", rspValid2, 0);
      toPos();
    end
    toNeg(); chk("t5 rsp_valid", rspValid2, 2'b01); chk("t5 result", rspResult2, 4'hF); toPos();
    toNeg(); chk("t5 busy", busy2, 0); toPos();

    // 6: reset mid-EXEC drops the operation
    reqOp2 = 6'b000_010; reqA2 = 8'h07; reqB2 = 8'h07;
    reqValid2 = 2'b01;
    step();
    reqValid2 = '0;
    step();
    reset = 1'b1;
    toNeg(); chk("t6 busy before", busy2, 1); toPos();
    reset = 1'b0;
    toNeg();
    chk("t6 busy", busy2, 0);
    chk("t6 rsp", {rspValid2, rspResult2}, 0);
    chk("t6 alu", {aluOp2, aluA2, aluB2}, 0);
    chk("t6 ready", reqReady2, 0);
    toPos();
    repeat (5) begin toNeg(); chk("t6 no rsp", rspValid2, 0); toPos(); end
    setReq(1, 3'b101, 4'h5, 4'hA);
    rspReady = 2'b11;
    reqValid = 2'b11;
    reqValid2 = 2'b11;
    toNeg(); chk("t6 prio dut2", reqReady2, 2'b01); chk("t6 prio dut1", reqReady, 2'b01); toPos();
    reqValid = '0;
    reqValid2 = '0;
    drain(20);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
